comp_serial: RTL and testbench
==============================

COMP_SERIAL -- requirements
Module: comp_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request to begin a conversion; sampled only in IDLE.
REQ-005 SHALL have port mode  input  2  operation: 00 pass, 01 negate (two's complement), 10 absolute value, 11 ones' complement.
REQ-006 SHALL have port a  input  WIDTH  operand, two's-complement signed.
REQ-007 SHALL have port busy  output  1  high while a conversion is in progress (SHIFT or DONE).
REQ-008 SHALL have port done  output  1  one-cycle pulse marking result valid.
REQ-009 SHALL have port o  output  WIDTH  result; held until the next completion.
REQ-010 SHALL have port ovf  output  1  result not representable; held with o.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-012 IDLE: when start=1, SHALL capture a and mode into internal registers, clear bit counter and found flag, and go to SHIFT; when start=0, SHALL stay in IDLE.
REQ-013 SHALL ignore start, a and mode while in SHIFT or DONE; captured values are not disturbed.
REQ-014 SHALL use effective negate = (mode=01) or (mode=10 and captured a[WIDTH-1]=1).
REQ-015 SHIFT: SHALL process exactly one operand bit per cycle, LSB first, bit index = counter 0..WIDTH-1.
REQ-016 When negating, output bit SHALL equal the input bit while found=0; found SHALL set after the first 1 bit; bits after found=1 SHALL be inverted.
REQ-017 When mode=11, every bit SHALL be inverted; for pass and non-negative abs, every bit SHALL be copied.
REQ-018 After processing bit WIDTH-1, SHALL go to DONE; total SHIFT occupancy is exactly WIDTH cycles.
REQ-019 DONE: SHALL load o and ovf from the assembled result, assert done for that single cycle, and return to IDLE on the next edge.
REQ-020 With start sampled at edge k: busy SHALL be high in cycles k+1..k+WIDTH+1, and done SHALL be high only in cycle k+WIDTH+1 (o valid from that cycle).
REQ-021 A start sampled in the first IDLE cycle after DONE SHALL be accepted; back-to-back throughput is one result per WIDTH+2 cycles.
REQ-022 ovf SHALL be 1 iff effective negate=1 and captured a = 1 followed by WIDTH-1 zeros; o SHALL then equal that same value.
REQ-023 Negating zero SHALL give o=0, ovf=0; pass and ones'-complement modes SHALL always give ovf=0.
REQ-024 o and ovf SHALL NOT change except at the DONE load or on reset; the partial result SHALL NOT be visible on o.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, o=0, ovf=0, done=0 and busy=0, and clear the counter, found flag and captured registers.
REQ-026 rst SHALL take priority over start and over any in-progress conversion; an aborted conversion SHALL produce no done pulse.
REQ-027 The first start after rst deasserts SHALL be accepted in the first cycle rst is low.

Verification
REQ-028 WIDTH=4, mode=01, a=0110, start 1 cycle -> busy 5 cycles; done in cycle k+5 with o=1010, ovf=0.
REQ-029 WIDTH=4, mode=01, a=1000 -> o=1000, ovf=1; mode=01, a=0000 -> o=0000, ovf=0.
REQ-030 WIDTH=8, mode=10: a=0xFD -> o=0x03; a=0x05 -> o=0x05; a=0x80 -> o=0x80, ovf=1.
REQ-031 WIDTH=8, mode=11, a=0x5A -> o=0xA5; mode=00, a=0x5A -> o=0x5A; change a and mode during SHIFT -> result unaffected.
REQ-032 WIDTH=8, start, then rst at cycle k+3 -> IDLE next cycle, o=0, no done; a new start then completes normally.
REQ-033 Start held high continuously -> a new conversion begins every WIDTH+2 cycles; each done pulse is exactly 1 cycle wide.

Source files
------------

// File: rtl/comp_serial.sv
// comp_serial: bit-serial two's-complement converter.
//   Computes pass / negate / absolute value / ones' complement of a signed
//   operand one bit per clock, LSB first, using the "copy up to and including
//   the first 1, then invert" negation rule.
//
// Ports
//   clk   in   clock, rising edge
//   rst   in   synchronous active-high reset
//   start in   begin a conversion (sampled only when idle)
//   mode  in   00 pass, 01 negate, 10 abs, 11 ones' complement
//   a     in   WIDTH-bit signed operand
//   busy  out  conversion in progress (SHIFT or DONE)
//   done  out  one-cycle pulse, o/ovf valid from this cycle
//   o     out  result, held until the next completion
//   ovf   out  result not representable (negating the most negative value)
module comp_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] o,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;      // captured operand, shifted right each SHIFT cycle
  logic [WIDTH-2:0] res_q;    // assembled result bits, filled from the top
  logic [WIDTH-1:0] res_d;
  logic [1:0]       mode_q;
  logic             neg_q;    // effective negate, fixed at capture time
  logic             found_q;
  logic             found_d;
  logic             out_bit;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] o_q;
  logic             ovf_q;

  // Per-bit transform of the current LSB of the operand.
  always_comb begin
    out_bit = a_q[0];
    found_d = found_q;
    if (mode_q == 2'b11) begin
      out_bit = ~a_q[0];
    end else if (neg_q) begin
      // Copy until the first 1 has passed, invert everything after it.
      out_bit = a_q[0] ^ found_q;
      found_d = found_q | a_q[0];
    end
    res_d = {out_bit, res_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      res_q   <= '0;
      mode_q  <= '0;
      neg_q   <= 1'b0;
      found_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      o_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            mode_q  <= mode;
            neg_q   <= (mode == 2'b01) || ((mode == 2'b10) && a[WIDTH-1]);
            res_q   <= '0;
            found_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          a_q     <= a_q >> 1;
          res_q   <= res_d[WIDTH-1:1];
          found_q <= found_d;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            // Outputs are registered, so the DONE-cycle load of o/ovf happens
            // on the edge entering DONE; the full result is res_d here.
            // Negation is a bijection, so the result equals the most negative
            // value only when the operand itself was that value.
            o_q     <= res_d;
            ovf_q   <= neg_q && (res_d == MIN_VAL);
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign o    = o_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_comp_serial.sv
// Testbench for comp_serial: one WIDTH=4 and one WIDTH=8 instance, directed
// vectors with hand-computed results, scoreboard queues popped by a monitor.
module tb_comp_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start4, busy4, done4, ovf4;
  logic [1:0] mode4;
  logic [3:0] a4, o4;
  logic       start8, busy8, done8, ovf8;
  logic [1:0] mode8;
  logic [7:0] a8, o8;

  int checks = 0;
  int errors = 0;

  logic [32:0] q4[$];
  logic [32:0] q8[$];
  logic [31:0] last4 = '0;
  logic [31:0] last8 = '0;

  comp_serial #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .mode(mode4), .a(a4),
    .busy(busy4), .done(done4), .o(o4), .ovf(ovf4)
  );

  comp_serial #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .mode(mode8), .a(a8),
    .busy(busy8), .done(done8), .o(o8), .ovf(ovf8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic get_busy(input int w);
    return (w == 4) ? busy4 : busy8;
  endfunction

  function automatic logic get_done(input int w);
    return (w == 4) ? done4 : done8;
  endfunction

  function automatic logic [31:0] get_o(input int w);
    return (w == 4) ? {28'b0, o4} : {24'b0, o8};
  endfunction

  task automatic drive(input int w, input logic s, input logic [1:0] m, input logic [31:0] av);
    if (w == 4) begin
      start4 = s; mode4 = m; a4 = av[3:0];
    end else begin
      start8 = s; mode8 = m; a8 = av[7:0];
    end
  endtask

  task automatic push(input int w, input logic [31:0] exp_o, input logic exp_ovf);
    if (w == 4) q4.push_back({exp_ovf, exp_o});
    else        q8.push_back({exp_ovf, exp_o});
  endtask

  // Scoreboard monitor: compares every done pulse against the queued result.
  always @(negedge clk) begin : monitor
    logic [32:0] e;
    if (done4) begin
      if (q4.size() == 0) check("w4_unexpected_done", 32'd1, 32'd0);
      else begin
        e = q4.pop_front();
        check("w4_o", {28'b0, o4}, e[31:0]);
        check("w4_ovf", {31'b0, ovf4}, {31'b0, e[32]});
        $display("W4 result o=%h ovf=%0d (expected o=%h ovf=%0d)", o4, ovf4, e[3:0], e[32]);
      end
    end
    if (done8) begin
      if (q8.size() == 0) check("w8_unexpected_done", 32'd1, 32'd0);
      else begin
        e = q8.pop_front();
        check("w8_o", {24'b0, o8}, e[31:0]);
        check("w8_ovf", {31'b0, ovf8}, {31'b0, e[32]});
        $display("W8 result o=%h ovf=%0d (expected o=%h ovf=%0d)", o8, ovf8, e[7:0], e[32]);
      end
    end
  end

  // One conversion with cycle-exact busy/done/o-hold checks. With scramble set,
  // start/mode/a are disturbed while the conversion is in SHIFT.
  task automatic run(input int w, input logic [1:0] m, input logic [31:0] av,
                     input logic [31:0] exp_o, input logic exp_ovf,
                     input bit scramble, input bit clr_rst);
    logic [31:0] prev;
    prev = (w == 4) ? last4 : last8;
    @(negedge clk);
    if (clr_rst) rst = 1'b0;
    drive(w, 1'b1, m, av);
    push(w, exp_o, exp_ovf);
    @(posedge clk);  // edge k: start sampled
    for (int i = 1; i <= w + 1; i++) begin
      @(negedge clk);
      if (scramble && i <= w) drive(w, 1'(i % 2), 2'(i), av ^ 32'(i * 37));
      else drive(w, 1'b0, m, av);
      check("busy_during", {31'b0, get_busy(w)}, 32'd1);
      check("done_timing", {31'b0, get_done(w)}, 32'(i == w + 1));
      if (i <= w) check("o_hold", get_o(w), prev);
    end
    @(negedge clk);
    check("busy_after", {31'b0, get_busy(w)}, 32'd0);
    check("done_after", {31'b0, get_done(w)}, 32'd0);
    if (w == 4) last4 = exp_o; else last8 = exp_o;
  endtask

  // Start held high for three conversions; checks the busy/done pattern.
  task automatic b2b(input int w, input logic [1:0] m, input logic [31:0] av,
                     input logic [31:0] exp_o, input logic exp_ovf);
    @(negedge clk);
    drive(w, 1'b1, m, av);
    for (int n = 0; n < 3; n++) push(w, exp_o, exp_ovf);
    @(posedge clk);
    for (int i = 1; i <= 3 * (w + 2); i++) begin
      @(negedge clk);
      if (i == 2 * (w + 2) + 1) drive(w, 1'b0, m, av);
      check("b2b_done", {31'b0, get_done(w)}, 32'((i % (w + 2)) == (w + 1)));
      check("b2b_busy", {31'b0, get_busy(w)}, 32'((i % (w + 2)) != 0));
    end
    if (w == 4) last4 = exp_o; else last8 = exp_o;
  endtask

  initial begin : timeout
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin : stim
    rst = 1'b1;
    drive(4, 1'b0, 2'b00, 32'h0);
    drive(8, 1'b0, 2'b00, 32'h0);
    repeat (3) @(negedge clk);
    check("rst_busy4", {31'b0, busy4}, 32'd0);
    check("rst_done4", {31'b0, done4}, 32'd0);
    check("rst_o4", {28'b0, o4}, 32'd0);
    check("rst_busy8", {31'b0, busy8}, 32'd0);
    check("rst_o8", {24'b0, o8}, 32'd0);
    check("rst_ovf8", {31'b0, ovf8}, 32'd0);
    rst = 1'b0;

    // WIDTH=4 vectors
    run(4, 2'b01, 32'h6, 32'hA, 1'b0, 1'b0, 1'b0);
    run(4, 2'b01, 32'h8, 32'h8, 1'b1, 1'b0, 1'b0);
    run(4, 2'b01, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    run(4, 2'b10, 32'hF, 32'h1, 1'b0, 1'b0, 1'b0);

    // WIDTH=8 vectors
    run(8, 2'b10, 32'hFD, 32'h03, 1'b0, 1'b0, 1'b0);
    run(8, 2'b10, 32'h05, 32'h05, 1'b0, 1'b0, 1'b0);
    run(8, 2'b10, 32'h80, 32'h80, 1'b1, 1'b0, 1'b0);
    run(8, 2'b11, 32'h5A, 32'hA5, 1'b0, 1'b0, 1'b0);
    run(8, 2'b00, 32'h5A, 32'h5A, 1'b0, 1'b0, 1'b0);
    run(8, 2'b01, 32'h01, 32'hFF, 1'b0, 1'b0, 1'b0);
    run(8, 2'b00, 32'h5A, 32'h5A, 1'b0, 1'b1, 1'b0);
    run(8, 2'b10, 32'h9C, 32'h64, 1'b0, 1'b1, 1'b0);

    // Abort by reset at edge k+3: no done, outputs cleared.
    @(negedge clk);
    drive(8, 1'b1, 2'b00, 32'h33);
    @(posedge clk);
    @(negedge clk);
    drive(8, 1'b0, 2'b00, 32'h33);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'b0, busy8}, 32'd0);
    check("abort_done", {31'b0, done8}, 32'd0);
    check("abort_o", {24'b0, o8}, 32'd0);
    check("abort_ovf", {31'b0, ovf8}, 32'd0);
    check("abort_o4", {28'b0, o4}, 32'd0);
    rst = 1'b0;
    last4 = '0;
    last8 = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_no_done", {31'b0, done8}, 32'd0);
    end

    // Start in the first cycle reset is low.
    rst = 1'b1;
    run(8, 2'b01, 32'h06, 32'hFA, 1'b0, 1'b0, 1'b1);

    // Continuous start
    b2b(4, 2'b11, 32'h5, 32'hA, 1'b0);
    b2b(8, 2'b01, 32'h80, 32'h80, 1'b1);

    repeat (3) @(negedge clk);
    check("q4_empty", 32'(q4.size()), 32'd0);
    check("q8_empty", 32'(q8.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
